// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the packed stall/flush control word, plus canned control patterns.
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_stall;
      logic id_ex_flush;
      logic ex_mem_stall;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } hazard_ctrl_t;

   localparam hazard_ctrl_t CTRL_NONE = '0;

   // Freeze everything upstream of MEM and bubble WB while memory is busy.
   localparam hazard_ctrl_t CTRL_FREEZE = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                            id_ex_stall: 1'b1, ex_mem_stall: 1'b1,
                                            mem_wb_flush: 1'b1, default: 1'b0};

   localparam hazard_ctrl_t CTRL_REDIRECT = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                              default: 1'b0};

   localparam hazard_ctrl_t CTRL_LOAD_USE = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                              id_ex_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the
// instruction in ID reads. x0 is never a real dependency.
module load_use_detect (
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_mem_read,
   output logic       load_use
);

   always_comb begin
      load_use = 1'b0;
      if (ex_mem_read && (ex_rd_addr != 5'd0)) begin
         load_use = (ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush priority mux plus a
// RUN/MEM_WAIT/ERR data-memory timeout FSM. Optional counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    id_rs1_addr,
   input  logic [4:0]    id_rs2_addr,
   input  logic [4:0]    ex_rd_addr,
   input  logic          ex_mem_read,
   input  logic          ex_redirect,
   input  logic          mem_req,
   input  logic          dmem_ready,
   output hazard_ctrl_t  ctrl,
   output hazard_state_t state,
   output logic          bus_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cycles,
   output logic [31:0]   flush_events
`endif
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   hazard_state_t state_q;
   logic [CW-1:0] cnt_q;
   logic          bus_err_q;
   hazard_ctrl_t  ctrl_d;
   logic          load_use;
   logic          mem_wait;

   load_use_detect u_load_use (
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .ex_rd_addr  (ex_rd_addr),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   assign mem_wait = mem_req && !dmem_ready;

   // Reset gates the Mealy path so ctrl clears asynchronously with the state.
   always_comb begin
      ctrl_d = CTRL_NONE;
      if (!reset) begin
         if (state_q == ERR) begin
            ctrl_d = CTRL_FREEZE;
         end else if (mem_wait) begin
            ctrl_d = CTRL_FREEZE;
         end else if (ex_redirect) begin
            ctrl_d = CTRL_REDIRECT;
         end else if (load_use) begin
            ctrl_d = CTRL_LOAD_USE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_wait) begin
                  state_q <= MEM_WAIT;
                  cnt_q   <= CW'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_wait) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
               end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
                  state_q   <= ERR;
                  bus_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ERR: begin
               state_q <= ERR;
            end
            default: begin
               state_q <= RUN;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign ctrl    = ctrl_d;
   assign state   = state_q;
   assign bus_err = bus_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_events_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         if (ctrl_d.pc_stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (ctrl_d.id_ex_flush) begin
            flush_events_q <= flush_events_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Ctrl bit order: pc_stall,if_id_stall,if_id_flush,id_ex_stall,id_ex_flush,ex_mem_stall,ex_mem_flush,mem_wb_flush.
module tb_pipeline_hazard_ctrl;
   import riscv_pkg::*;

   localparam logic [7:0] C_ZERO = 8'b0000_0000;
   localparam logic [7:0] C_LU   = 8'b1100_1000;
   localparam logic [7:0] C_RD   = 8'b0010_1000;
   localparam logic [7:0] C_FRZ  = 8'b1101_0101;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
   logic          mem_read = 1'b0, redirect = 1'b0, mem_req = 1'b0, ready = 1'b0;
   hazard_ctrl_t  ctrl;
   hazard_state_t state;
   logic          bus_err;
   logic [7:0]    cb;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]   stall_cycles, flush_events;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   assign cb = ctrl;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs1_addr (rs1),
      .id_rs2_addr (rs2),
      .ex_rd_addr  (rd),
      .ex_mem_read (mem_read),
      .ex_redirect (redirect),
      .mem_req     (mem_req),
      .dmem_ready  (ready),
      .ctrl        (ctrl),
      .state       (state),
      .bus_err     (bus_err)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_events(flush_events)
`endif
   );

   task automatic setin(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic mr, input logic rdr, input logic rq, input logic rdy);
      @(negedge clk);
      rs1 = a1; rs2 = a2; rd = d;
      mem_read = mr; redirect = rdr; mem_req = rq; ready = rdy;
      #1;
   endtask

   task automatic tick(input logic [7:0] exp);
      exp_stall += int'(exp[7]);
      exp_flush += int'(exp[3]);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rs1 = 5'd5; rs2 = 5'd5; rd = 5'd5; mem_read = 1'b1; mem_req = 1'b1; ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL reset_ctrl: ctrl=%b expected=%b", cb, C_ZERO); end
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL reset_state: state=%0d expected=%0d", state, RUN); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: bus_err=%b expected=0", bus_err); end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL reset_hold_state: state=%0d expected=%0d", state, RUN); end
      @(negedge clk);
      reset = 1'b0;
      setin(0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL idle_ctrl: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
   endtask

   task automatic test_load_use();
      setin(5'd3, 5'd5, 5'd5, 1, 0, 0, 0);
      n_checks++; if (cb !== C_LU) begin n_fail++; $display("FAIL lu_rs2: ctrl=%b expected=%b", cb, C_LU); end
      tick(C_LU);
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL lu_state: state=%0d expected=%0d", state, RUN); end
      setin(5'd0, 5'd0, 5'd5, 0, 0, 0, 0);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL lu_one_cycle: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
      setin(5'd9, 5'd1, 5'd9, 1, 0, 0, 0);
      n_checks++; if (cb !== C_LU) begin n_fail++; $display("FAIL lu_rs1: ctrl=%b expected=%b", cb, C_LU); end
      tick(C_LU);
      setin(5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL lu_x0: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
      setin(5'd7, 5'd7, 5'd7, 0, 0, 0, 0);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL lu_no_load: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
      setin(5'd6, 5'd8, 5'd7, 1, 0, 0, 0);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL lu_no_match: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
   endtask

   task automatic test_redirect();
      setin(0, 0, 0, 0, 1, 0, 0);
      n_checks++; if (cb !== C_RD) begin n_fail++; $display("FAIL redir: ctrl=%b expected=%b", cb, C_RD); end
      tick(C_RD);
      setin(5'd3, 5'd5, 5'd5, 1, 1, 0, 0);
      n_checks++; if (cb !== C_RD) begin n_fail++; $display("FAIL redir_lu: ctrl=%b expected=%b", cb, C_RD); end
      tick(C_RD);
   endtask

   task automatic test_mem_wait();
      setin(0, 0, 0, 0, 0, 1, 1);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL single_cycle_ctrl: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL single_cycle_state: state=%0d expected=%0d", state, RUN); end
      for (int i = 0; i < 3; i++) begin
         if (i == 1) setin(5'd4, 5'd0, 5'd4, 1, 0, 1, 0);
         else        setin(0, 0, 0, 0, 0, 1, 0);
         n_checks++; if (cb !== C_FRZ) begin n_fail++; $display("FAIL mw_ctrl[%0d]: ctrl=%b expected=%b", i, cb, C_FRZ); end
         tick(C_FRZ);
         n_checks++; if (state !== MEM_WAIT) begin n_fail++; $display("FAIL mw_state[%0d]: state=%0d expected=%0d", i, state, MEM_WAIT); end
      end
      setin(0, 0, 0, 0, 0, 1, 1);
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL mw_exit_ctrl: ctrl=%b expected=%b", cb, C_ZERO); end
      tick(C_ZERO);
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL mw_exit_state: state=%0d expected=%0d", state, RUN); end
   endtask

   task automatic test_redirect_during_wait();
      for (int i = 0; i < 2; i++) begin
         setin(0, 0, 0, 0, 1, 1, 0);
         n_checks++; if (cb !== C_FRZ) begin n_fail++; $display("FAIL rw_ctrl[%0d]: ctrl=%b expected=%b", i, cb, C_FRZ); end
         tick(C_FRZ);
      end
      setin(0, 0, 0, 0, 1, 1, 1);
      n_checks++; if (cb !== C_RD) begin n_fail++; $display("FAIL rw_exit_ctrl: ctrl=%b expected=%b", cb, C_RD); end
      tick(C_RD);
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL rw_exit_state: state=%0d expected=%0d", state, RUN); end
      setin(0, 0, 0, 0, 0, 0, 0);
      tick(C_ZERO);
   endtask

   task automatic test_perf();
`ifdef HAZARD_PERF_CNT_EN
      n_checks++; if (stall_cycles !== 32'(exp_stall)) begin n_fail++; $display("FAIL perf_stall: stall_cycles=%0d expected=%0d", stall_cycles, exp_stall); end
      n_checks++; if (flush_events !== 32'(exp_flush)) begin n_fail++; $display("FAIL perf_flush: flush_events=%0d expected=%0d", flush_events, exp_flush); end
`endif
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 4; i++) begin
         setin(0, 0, 0, 0, 0, 1, 0);
         n_checks++; if (cb !== C_FRZ) begin n_fail++; $display("FAIL to_ctrl[%0d]: ctrl=%b expected=%b", i, cb, C_FRZ); end
         tick(C_FRZ);
         n_checks++; if (state !== MEM_WAIT || bus_err !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d]: state=%0d bus_err=%b expected state=%0d bus_err=0", i, state, bus_err, MEM_WAIT); end
      end
      setin(0, 0, 0, 0, 0, 1, 0);
      tick(C_FRZ);
      n_checks++; if (state !== ERR) begin n_fail++; $display("FAIL to_err_state: state=%0d expected=%0d", state, ERR); end
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err_bus: bus_err=%b expected=1", bus_err); end
      for (int i = 0; i < 3; i++) begin
         setin(5'd5, 5'd5, 5'd5, 1, 1, 0, 1);
         n_checks++; if (cb !== C_FRZ) begin n_fail++; $display("FAIL err_ctrl[%0d]: ctrl=%b expected=%b", i, cb, C_FRZ); end
         tick(C_FRZ);
         n_checks++; if (state !== ERR || bus_err !== 1'b1) begin n_fail++; $display("FAIL err_hold[%0d]: state=%0d bus_err=%b expected state=%0d bus_err=1", i, state, bus_err, ERR); end
      end
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_checks++; if (state !== RUN || bus_err !== 1'b0) begin n_fail++; $display("FAIL async_reset: state=%0d bus_err=%b expected state=%0d bus_err=0", state, bus_err, RUN); end
      n_checks++; if (cb !== C_ZERO) begin n_fail++; $display("FAIL async_reset_ctrl: ctrl=%b expected=%b", cb, C_ZERO); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      setin(0, 0, 0, 0, 1, 0, 0);
      n_checks++; if (cb !== C_RD) begin n_fail++; $display("FAIL post_reset_redir: ctrl=%b expected=%b", cb, C_RD); end
      tick(C_RD);
      n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL post_reset_state: state=%0d expected=%0d", state, RUN); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_redirect_during_wait();
      test_perf();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64, max consecutive data-memory wait cycles before error.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr  input  5 each  source registers of instruction in ID.
REQ-005 SHALL have ports ex_rd_addr  input  5, and ex_mem_read  input  1  destination register and load flag of instruction in EX.
REQ-006 SHALL have port ex_redirect  input  1  taken branch/jump/jalr resolved in EX.
REQ-007 SHALL have ports mem_req  input  1, and dmem_ready  input  1  load/store in MEM and memory completion.
REQ-008 SHALL have port ctrl  output  hazard_ctrl_t  stall/flush bits: pc_stall, if_id_stall/flush, id_ex_stall/flush, ex_mem_stall/flush, mem_wb_flush.
REQ-009 SHALL have ports state  output  hazard_state_t, and bus_err  output  1  sticky timeout flag.

Function
REQ-010 SHALL implement states RUN, MEM_WAIT and ERR.
REQ-011 SHALL compute ctrl combinationally from the current state and inputs (Mealy), with zero-cycle latency.
REQ-012 SHALL treat a load-use hazard as ex_mem_read=1, ex_rd_addr!=0, and ex_rd_addr matching id_rs1_addr or id_rs2_addr.
REQ-013 SHALL treat a memory wait as mem_req=1 and dmem_ready=0, in RUN or MEM_WAIT.
REQ-014 SHALL, during a memory wait, assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush, and no other bits.
REQ-015 SHALL, in RUN with ex_redirect and no memory wait, assert if_id_flush and id_ex_flush only.
REQ-016 SHALL, in RUN with load-use, no redirect and no memory wait, assert pc_stall, if_id_stall and id_ex_flush only.
REQ-017 SHALL apply priority memory wait > redirect > load-use; a redirect during a memory wait is not lost, because EX is frozen and re-presents it.
REQ-018 SHALL transition RUN->MEM_WAIT on a memory wait; the wait counter loads 1.
REQ-019 SHALL, in MEM_WAIT, increment the counter each wait cycle, and transition to RUN on dmem_ready=1 or mem_req=0, with ctrl following RUN rules in that exit cycle.
REQ-020 SHALL transition MEM_WAIT->ERR when the counter equals MEM_TIMEOUT and dmem_ready=0; the counter saturates and does not wrap.
REQ-021 SHALL, in ERR, assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush and bus_err, ignore all inputs, and leave ERR only on reset.
REQ-022 SHALL not enter MEM_WAIT when mem_req and dmem_ready are both 1 in RUN (single-cycle access).

Reset
REQ-023 SHALL, on reset assertion, immediately (asynchronously) force state=RUN, counter=0, bus_err=0 and all ctrl bits 0, including mid-wait or in ERR.
REQ-024 SHALL evaluate the first RUN rules on the first rising edge after reset deassertion.

Configuration
REQ-025 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs stall_cycles and flush_events (32 bits each, reset 0, wrapping): stall_cycles counts cycles with pc_stall=1, and flush_events counts cycles with id_ex_flush=1.
REQ-026 SHALL, without HAZARD_PERF_CNT_EN, have no such ports or counters, with all other behaviour identical.

Structure
REQ-027 SHALL define hazard_state_t (enum RUN/MEM_WAIT/ERR) and hazard_ctrl_t (packed struct of the 8 bits) in riscv_pkg.
REQ-028 SHALL place load-use comparison in one combinational sub-module, load_use_detect; the FSM, counter and priority mux stay in pipeline_hazard_ctrl.

Verification
REQ-029 SHALL verify load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle; ex_rd=0 -> no stall.
REQ-030 SHALL verify redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
REQ-031 SHALL verify mem_req=1 with dmem_ready low for 3 cycles -> 3 cycles of all stalls plus mem_wb_flush, state MEM_WAIT, then RUN with ctrl=0 on the ready cycle.
REQ-032 SHALL verify MEM_TIMEOUT=4 with ready never asserted -> ERR and bus_err=1 after 4 wait cycles, persisting until reset; reset mid-ERR clears asynchronously.
REQ-033 SHALL verify redirect during a 2-cycle wait -> flushes suppressed during the wait and asserted on the exit cycle.
REQ-034 SHALL verify, with HAZARD_PERF_CNT_EN, that after the above sequence stall_cycles and flush_events match bench-counted values.
